// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives two ROM read addresses per cycle (PC, PC+1), captures the words
// into a small in-order queue and presents up to two instructions per cycle to decode.
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH_IM = 8,
  parameter int INSTR_WIDTH   = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter logic [ADDR_WIDTH_IM-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_WIDTH_IM-1:0] address_1,
  output logic [ADDR_WIDTH_IM-1:0] address_2,
  input  logic [INSTR_WIDTH-1:0]   read_data_1,
  input  logic [INSTR_WIDTH-1:0]   read_data_2,
  input  logic                     fetch_enable,
  input  logic                     redirect_valid,
  input  logic [ADDR_WIDTH_IM-1:0] redirect_pc,
  output logic                     out_valid_1,
  output logic [INSTR_WIDTH-1:0]   out_instr_1,
  output logic [ADDR_WIDTH_IM-1:0] out_pc_1,
  output logic                     out_valid_2,
  output logic [INSTR_WIDTH-1:0]   out_instr_2,
  output logic [ADDR_WIDTH_IM-1:0] out_pc_2,
  input  logic                     out_ready_1,
  input  logic                     out_ready_2,
  output logic [$clog2(FIFO_DEPTH):0] occupancy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  logic [ADDR_WIDTH_IM-1:0] r_pc;
  logic [INSTR_WIDTH-1:0]   r_instr_q [FIFO_DEPTH];
  logic [ADDR_WIDTH_IM-1:0] r_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_head;
  logic [PTR_W-1:0]         r_tail;
  logic [OCC_W-1:0]         r_occ;

  logic [OCC_W-1:0] w_free;
  logic [1:0]       w_push_n;
  logic             w_pop1;
  logic             w_pop2;
  logic [1:0]       w_pop_n;
  logic [PTR_W-1:0] w_head_nxt;
  logic [PTR_W-1:0] w_tail_nxt;

  assign address_1 = r_pc;
  assign address_2 = r_pc + ADDR_WIDTH_IM'(1);

  assign w_head_nxt = r_head + PTR_W'(1);
  assign w_tail_nxt = r_tail + PTR_W'(1);

  assign out_valid_1 = (r_occ != '0);
  assign out_valid_2 = (r_occ >= OCC_W'(2));
  assign out_instr_1 = r_instr_q[r_head];
  assign out_pc_1    = r_pc_q[r_head];
  assign out_instr_2 = r_instr_q[w_head_nxt];
  assign out_pc_2    = r_pc_q[w_head_nxt];
  assign occupancy   = r_occ;

  // Free space is taken from the start-of-cycle count; same-cycle pops give no credit.
  assign w_free = DEPTH_C - r_occ;

  always_comb begin
    w_push_n = 2'd0;
    if (fetch_enable) begin
      if (w_free >= OCC_W'(2)) w_push_n = 2'd2;
      else                     w_push_n = w_free[1:0];
    end
  end

  assign w_pop1  = out_valid_1 & out_ready_1;
  assign w_pop2  = w_pop1 & out_valid_2 & out_ready_2;
  assign w_pop_n = {1'b0, w_pop1} + {1'b0, w_pop2};

  // Payload storage needs no reset; validity is carried by the pointers and count.
  always_ff @(posedge clk) begin
    if (!redirect_valid) begin
      if (w_push_n != 2'd0) begin
        r_instr_q[r_tail] <= read_data_1;
        r_pc_q[r_tail]    <= r_pc;
      end
      if (w_push_n == 2'd2) begin
        r_instr_q[w_tail_nxt] <= read_data_2;
        r_pc_q[w_tail_nxt]    <= address_2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc   <= RESET_PC;
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (redirect_valid) begin
      r_pc   <= redirect_pc;
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      r_pc   <= r_pc + ADDR_WIDTH_IM'(w_push_n);
      r_head <= r_head + PTR_W'(w_pop_n);
      r_tail <= r_tail + PTR_W'(w_push_n);
      r_occ  <= r_occ + OCC_W'(w_push_n) - OCC_W'(w_pop_n);
    end
  end

endmodule
